// File: rtl/tc503_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tc503_timer_pkg
// Description : Shared types and constants for the two-digit countdown timer.
//               Holds the timer state encoding, the digit-to-segment table
//               (bit0 = segment a, active high) and a divider-free tens/ones
//               splitter for 0..99 values.
// Revision    : 1.0 - initial release
// ============================================================================
package tc503_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        ALARM   = 2'd2
    } timer_state_t;

    // Entries 10..15 are unreachable (digits are always 0..9) and kept blank.
    localparam logic [15:0][6:0] c_seg_table = {
        7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Returns {tens, ones} for a value in 0..99 using a chain of
    // compare/subtract stages instead of a divider.
    function automatic logic [7:0] split_digits(input logic [6:0] value);
        logic [6:0] rest;
        logic [3:0] tens;
        rest = value;
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rest >= 7'd10) begin
                rest = rest - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rest[3:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : quad_decoder
// Description : Quadrature encoder front end. Synchronises A and B through
//               two flops, detects rising edges of synced A and steps a
//               saturating up/down counter (B=0 -> +1, B=1 -> -1).
// Ports       : clk, rst_n    clock, async active-low reset
//               i_a, i_b      raw encoder phases
//               i_hold        when high, edges are reported but not counted
//               o_step        one-cycle pulse on every detected A rise
//               o_value       counter value, 0..MAX_VAL
// Revision    : 1.0 - initial release
// ============================================================================
module quad_decoder #(
    parameter int WIDTH   = 7,
    parameter int MAX_VAL = 99
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_hold,
    output logic             o_step,
    output logic [WIDTH-1:0] o_value
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_VAL);

    logic [1:0]       r_a_sync;
    logic [1:0]       r_b_sync;
    logic             r_a_prev;
    logic [WIDTH-1:0] r_value;
    logic             w_rise;

    assign w_rise = r_a_sync[1] & ~r_a_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sync <= 2'b00;
            r_b_sync <= 2'b00;
            r_a_prev <= 1'b0;
            r_value  <= '0;
        end else begin
            r_a_sync <= {r_a_sync[0], i_a};
            r_b_sync <= {r_b_sync[0], i_b};
            r_a_prev <= r_a_sync[1];
            if (w_rise && !i_hold) begin
                if (!r_b_sync[1]) begin
                    if (r_value != c_max) r_value <= r_value + 1'b1;
                end else begin
                    if (r_value != '0) r_value <= r_value - 1'b1;
                end
            end
        end
    end

    assign o_step  = w_rise;
    assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/tc503_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tc503_countdown_timer
// Description : Two-digit (00..99 s) countdown timer tile. Encoder 0 sets the
//               preset, countdown0 starts/restarts/acknowledges, a muxed
//               7-segment display shows preset/remaining time, pwm0 carries
//               the alarm tone and encoders 1/2 set two 16-level dimmers.
// Ports       : clk, rst_n  clock, async active-low reset
//               ena         tile enable (ignored)
//               ui_in       [0..5] enc0/1/2 A,B  [7] countdown0 start
//               uo_out      [6:0] segments g..a  [7] digit select (1=tens)
//               uio_in      unused
//               uio_out     [0] alarm tone  [1] pwm1  [2] pwm2
//               uio_oe      constant 8'h07
// Revision    : 1.0 - initial release
// ============================================================================
module tc503_countdown_timer
    import tc503_timer_pkg::*;
#(
    parameter int TICK_DIV = 10_000_000,
    parameter int MUX_DIV  = 10_000,
    parameter int TONE_DIV = 5_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int c_tick_w = $clog2(TICK_DIV);
    localparam int c_mux_w  = $clog2(MUX_DIV);
    localparam int c_tone_w = $clog2(TONE_DIV);

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam logic [c_mux_w-1:0]  c_mux_last  = c_mux_w'(MUX_DIV - 1);
    localparam logic [c_tone_w-1:0] c_tone_last = c_tone_w'(TONE_DIV - 1);

    // Start input synchroniser and edge detect
    logic [1:0] r_start_sync;
    logic       r_start_prev;
    logic       w_start_rise;

    // Encoder outputs
    logic [6:0] w_preset;
    logic [3:0] w_duty1;
    logic [3:0] w_duty2;
    logic       w_enc0_step;
    logic       w_enc1_step;
    logic       w_enc2_step;

    // Timer state
    timer_state_t        r_state;
    timer_state_t        w_state_next;
    logic [6:0]          r_remaining;
    logic [6:0]          w_remaining_next;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic [c_tick_w-1:0] w_tick_next;

    // Display, tone and PWM
    logic [c_mux_w-1:0]  r_mux_cnt;
    logic                r_digit_sel;
    logic [c_tone_w-1:0] r_tone_cnt;
    logic                r_tone;
    logic [3:0]          r_pwm_cnt;
    logic [6:0]          w_disp_value;
    logic [7:0]          w_digits;
    logic [3:0]          w_digit;

    logic w_unused;
    assign w_unused = &{1'b0, ena, uio_in, ui_in[6], w_enc1_step, w_enc2_step};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_sync <= 2'b00;
            r_start_prev <= 1'b0;
        end else begin
            r_start_sync <= {r_start_sync[0], ui_in[7]};
            r_start_prev <= r_start_sync[1];
        end
    end

    assign w_start_rise = r_start_sync[1] & ~r_start_prev;

    // The preset is frozen while a countdown is in progress.
    quad_decoder #(.WIDTH(7), .MAX_VAL(99)) u_enc0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_a     (ui_in[0]),
        .i_b     (ui_in[1]),
        .i_hold  (r_state == RUNNING),
        .o_step  (w_enc0_step),
        .o_value (w_preset)
    );

    quad_decoder #(.WIDTH(4), .MAX_VAL(15)) u_enc1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_a     (ui_in[2]),
        .i_b     (ui_in[3]),
        .i_hold  (1'b0),
        .o_step  (w_enc1_step),
        .o_value (w_duty1)
    );

    quad_decoder #(.WIDTH(4), .MAX_VAL(15)) u_enc2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_a     (ui_in[4]),
        .i_b     (ui_in[5]),
        .i_hold  (1'b0),
        .o_step  (w_enc2_step),
        .o_value (w_duty2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_remaining <= 7'd0;
            r_tick_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_tick_cnt  <= w_tick_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_tick_next      = r_tick_cnt;
        case (r_state)
            IDLE: begin
                if (w_start_rise && (w_preset != 7'd0)) begin
                    w_state_next     = RUNNING;
                    w_remaining_next = w_preset;
                    w_tick_next      = '0;
                end
            end
            RUNNING: begin
                // A restart takes priority over a second boundary.
                if (w_start_rise) begin
                    w_remaining_next = w_preset;
                    w_tick_next      = '0;
                end else if (r_tick_cnt == c_tick_last) begin
                    w_tick_next      = '0;
                    w_remaining_next = r_remaining - 7'd1;
                    if (r_remaining == 7'd1) w_state_next = ALARM;
                end else begin
                    w_tick_next = r_tick_cnt + 1'b1;
                end
            end
            ALARM: begin
                if (w_start_rise || w_enc0_step) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Tone phase is held cleared outside ALARM so each alarm starts low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
        end else if (r_state == ALARM) begin
            if (r_tone_cnt == c_tone_last) begin
                r_tone_cnt <= '0;
                r_tone     <= ~r_tone;
            end else begin
                r_tone_cnt <= r_tone_cnt + 1'b1;
            end
        end else begin
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mux_cnt   <= '0;
            r_digit_sel <= 1'b0;
            r_pwm_cnt   <= 4'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
            if (r_mux_cnt == c_mux_last) begin
                r_mux_cnt   <= '0;
                r_digit_sel <= ~r_digit_sel;
            end else begin
                r_mux_cnt <= r_mux_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        case (r_state)
            RUNNING: w_disp_value = r_remaining;
            ALARM:   w_disp_value = 7'd0;
            default: w_disp_value = w_preset;
        endcase
    end

    assign w_digits = split_digits(w_disp_value);
    assign w_digit  = r_digit_sel ? w_digits[7:4] : w_digits[3:0];

    assign uo_out  = {r_digit_sel, c_seg_table[w_digit]};
    // Gate with state so the tone drops in the same cycle the alarm clears.
    assign uio_out = {5'b00000,
                      (r_pwm_cnt < w_duty2),
                      (r_pwm_cnt < w_duty1),
                      (r_state == ALARM) & r_tone};
    assign uio_oe  = 8'b0000_0111;

endmodule
`default_nettype wire

// File: tb/tb_tc503_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tc503_countdown_timer
// Description : Self-checking bench for the countdown timer. A behavioural
//               model derives every expected output from elapsed cycle
//               counts (seconds, mux phase, tone phase, PWM phase) and is
//               compared against the DUT on every falling edge, plus directed
//               literal checks of the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tc503_countdown_timer;

    localparam int TICK = 20;
    localparam int MUXD = 4;
    localparam int TONE = 3;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tc503_countdown_timer #(
        .TICK_DIV (TICK),
        .MUX_DIV  (MUXD),
        .TONE_DIV (TONE)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: mode 0=idle, 1=running (alarm derived from elapsed time)
    int m_mode, m_preset, m_duty1, m_duty2;
    int m_run_start, m_run_preset, m_rst_edge;
    bit chk_en = 1'b0;
    int n_checks = 0;
    int n_errors = 0;
    int hi1, hi2;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int seg_of(input int d);
        case (d)
            0: return 'h3F; 1: return 'h06; 2: return 'h5B; 3: return 'h4F;
            4: return 'h66; 5: return 'h6D; 6: return 'h7D; 7: return 'h07;
            8: return 'h7F; 9: return 'h6F;
            default: return 0;
        endcase
    endfunction

    function automatic int eff_mode(input int m);
        if (m_mode == 1 && (m - m_run_start) >= m_run_preset * TICK) return 2;
        return m_mode;
    endfunction

    function automatic int exp_uo(input int m);
        int k, sel, mode, val, dig;
        k    = m - m_rst_edge;
        sel  = (k / MUXD) % 2;
        mode = eff_mode(m);
        if (mode == 0)      val = m_preset;
        else if (mode == 1) val = m_run_preset - (m - m_run_start) / TICK;
        else                val = 0;
        dig = (sel == 1) ? val / 10 : val % 10;
        return sel * 128 + seg_of(dig);
    endfunction

    function automatic int exp_uio(input int m);
        int pc, p0, p1, p2;
        pc = (m - m_rst_edge) % 16;
        p1 = (pc < m_duty1) ? 1 : 0;
        p2 = (pc < m_duty2) ? 1 : 0;
        p0 = 0;
        if (eff_mode(m) == 2)
            p0 = ((m - (m_run_start + m_run_preset * TICK)) / TONE) % 2;
        return p2 * 4 + p1 * 2 + p0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("uo_out", int'(uo_out), exp_uo(cyc));
            check("uio_out", int'(uio_out), exp_uio(cyc));
        end
    end

    task automatic step_clk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int sat(input int v, input int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    task automatic enc_step(input int idx, input bit ccw);
        int n, mode;
        ui_in[2*idx+1] = ccw;
        step_clk(2);
        n = cyc;
        ui_in[2*idx] = 1'b1;
        chk_en = 1'b0;
        step_clk(3);
        mode = eff_mode(n + 2);
        if (idx == 0) begin
            if (mode != 1) begin
                m_preset = sat(m_preset + (ccw ? -1 : 1), 99);
                m_mode   = 0;
            end
        end else if (idx == 1) begin
            m_duty1 = sat(m_duty1 + (ccw ? -1 : 1), 15);
        end else begin
            m_duty2 = sat(m_duty2 + (ccw ? -1 : 1), 15);
        end
        chk_en = 1'b1;
        ui_in[2*idx] = 1'b0;
        step_clk(2);
        ui_in[2*idx+1] = 1'b0;
    endtask

    task automatic start_pulse();
        int n, mode;
        n = cyc;
        ui_in[7] = 1'b1;
        chk_en = 1'b0;
        step_clk(3);
        mode = eff_mode(n + 2);
        if (mode == 2) begin
            m_mode = 0;
        end else if (mode == 1 || m_preset > 0) begin
            m_mode       = 1;
            m_run_start  = n + 3;
            m_run_preset = m_preset;
        end
        chk_en = 1'b1;
        ui_in[7] = 1'b0;
        step_clk(3);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        chk_en = 1'b0;
        #1;
        check("rst_uo_out", int'(uo_out), 'h3F);
        check("rst_uio_out", int'(uio_out), 0);
        check("rst_uio_oe", int'(uio_oe), 'h07);
        step_clk(3);
        ui_in = 8'h00;
        rst_n = 1'b1;
        m_rst_edge = cyc;
        m_mode = 0; m_preset = 0; m_duty1 = 0; m_duty2 = 0;
        m_run_start = 0; m_run_preset = 0;
        chk_en = 1'b1;
        step_clk(2);
    endtask

    task automatic digit_check(input bit sel, input int seg, input string tag);
        @(negedge clk);
        for (int i = 0; i < 3 * MUXD && uo_out[7] !== sel; i++) @(negedge clk);
        check({tag, "_sel"}, int'(uo_out[7]), int'(sel));
        check(tag, int'(uo_out[6:0]), seg);
        step_clk(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        step_clk(3);
        do_reset();

        // Preset 5, then saturation at 99 and 0
        for (int i = 0; i < 5; i++) enc_step(0, 1'b0);
        digit_check(1'b0, 'h6D, "preset5_ones");
        digit_check(1'b1, 'h3F, "preset5_tens");
        for (int i = 0; i < 120; i++) enc_step(0, 1'b0);
        digit_check(1'b0, 'h6F, "preset99_ones");
        digit_check(1'b1, 'h6F, "preset99_tens");
        for (int i = 0; i < 105; i++) enc_step(0, 1'b1);
        digit_check(1'b0, 'h3F, "preset0_ones");

        // Countdown from 3 into alarm, cleared by start
        for (int i = 0; i < 3; i++) enc_step(0, 1'b0);
        start_pulse();
        digit_check(1'b0, 'h4F, "run3_ones");
        step_clk(70);
        check("alarm_display", int'(uo_out[6:0]), 'h3F);
        start_pulse();
        check("cleared_pwm0", int'(uio_out[0]), 0);
        digit_check(1'b0, 'h4F, "idle3_ones");

        // Alarm cleared by one encoder step instead
        start_pulse();
        step_clk(65);
        enc_step(0, 1'b0);
        digit_check(1'b0, 'h66, "idle4_ones");

        // Dimmers
        for (int i = 0; i < 4; i++) enc_step(1, 1'b0);
        for (int i = 0; i < 16; i++) enc_step(2, 1'b0);
        hi1 = 0; hi2 = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            hi1 += int'(uio_out[1]);
            hi2 += int'(uio_out[2]);
        end
        step_clk(1);
        check("pwm1_high_count", hi1, 4);
        check("pwm2_high_count", hi2, 15);

        // Preset 0 never starts
        for (int i = 0; i < 4; i++) enc_step(0, 1'b1);
        start_pulse();
        step_clk(30);
        check("preset0_no_alarm", int'(uio_out[0]), 0);
        digit_check(1'b0, 'h3F, "preset0_idle_ones");

        // Reset in the middle of a countdown
        for (int i = 0; i < 3; i++) enc_step(0, 1'b0);
        start_pulse();
        step_clk(25);
        do_reset();

        // Randomised operation mix against the model
        for (int op = 0; op < 200; op++) begin
            int r;
            r = int'($urandom_range(0, 40));
            if (r < 20) begin
                int idx, cnt;
                bit dir;
                idx = int'($urandom_range(0, 2));
                dir = 1'($urandom_range(0, 1));
                cnt = int'($urandom_range(1, 6));
                for (int j = 0; j < cnt; j++) enc_step(idx, dir);
            end else if (r < 28) begin
                start_pulse();
            end else if (r < 40) begin
                step_clk(int'($urandom_range(1, 80)));
            end else begin
                do_reset();
            end
        end

        chk_en = 1'b0;
        step_clk(1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
